uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Transmit controller for the UART transmitter path. It sits directly upstream of the 8-bit PISO shift stage and downstream of the byte source.
- Accepts a byte over a valid/ready handshake.
- Drives the PISO load/shift strobes at baud-aligned instants.
- Frames the PISO serial output with start, stop and optional parity bits onto the tx line.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal minimum 2.
DATA_BITS, 8, data bits per frame; fixed at 8 to match the PISO width.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
tx_data  in  8  byte to send; sampled only on the accept cycle
tx_valid  in  1  source has a byte
tx_ready  out  1  block can accept; high only in IDLE
piso_data  out  8  parallel word to PISO; combinational pass-through of tx_data
piso_load  out  1  one-cycle load strobe to PISO
piso_shift  out  1  one-cycle shift strobe to PISO
piso_out  in  1  registered serial bit from PISO, MSB first
tx  out  1  UART line, idle high
busy  out  1  high from the accept edge until the frame completes
tx_done  out  1  one-cycle pulse in the last clock of the stop bit

Behaviour:
- States: IDLE, START, DATA, (PARITY), STOP. Baud counter runs 0..CLKS_PER_BIT-1. Bit index runs 0..7.
- Reset (asynchronous): state=IDLE, counters=0, tx=1, tx_ready=1, busy=0, tx_done=0, piso_load=0, piso_shift=0. Reset mid-frame aborts the frame and returns tx to 1 immediately.
- IDLE: tx=1, tx_ready=1.
  - A cycle with tx_valid & tx_ready is the accept cycle: piso_load=1 combinationally in that cycle, and tx_data is latched internally.
  - Next edge: state→START, counter=0, busy=1.
- START: tx=0 for CLKS_PER_BIT cycles. piso_shift=1 in the final cycle (counter==CLKS_PER_BIT-1).
  - At that edge the PISO presents bit7 and state→DATA, so both change on the same edge.
- DATA: tx=piso_out. Each bit lasts CLKS_PER_BIT cycles.
  - piso_shift=1 in the final cycle of bits 0..6 only.
  - After the final cycle of bit index 7: state→STOP, or →PARITY if enabled.
- STOP: tx=1 for CLKS_PER_BIT cycles. tx_done=1 in the final cycle. Next edge: state→IDLE, busy=0.
- tx is a mux of registered state and registered piso_out only; no other combinational path to tx.
- tx_valid outside IDLE is ignored. Minimum one IDLE cycle between frames.
- Frame length: 1 accept cycle + 10×CLKS_PER_BIT (11× with parity).
- piso_load and piso_shift are never high in the same cycle.

Optional Feature:
UART_TX_PARITY_EN:
- Defined: PARITY state inserted between DATA and STOP. tx = even parity (XOR of the latched byte) for CLKS_PER_BIT cycles. No piso_shift is issued in this state.
- Undefined: DATA goes directly to STOP. The latched-byte register and XOR logic are omitted.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - DATA_BITS=8
  - helper function for counter width, clog2(CLKS_PER_BIT)
- One sub-module, uart_baud_counter. It takes clk, reset and a clear input, and outputs bit_end, high when count==CLKS_PER_BIT-1. It is reused later by the receiver.

Test Plan:
- All tests use CLKS_PER_BIT=4 and the PISO connected.
1. Reset released, no traffic → tx=1, tx_ready=1, busy=0, no strobes for 100 cycles.
2. Send 0xA5 → piso_load pulse on the accept cycle. tx sequence: 0×4, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1×4. tx_done pulse 40 cycles after the accept edge. Exactly 8 piso_shift pulses.
3. Back-to-back 0x00 then 0xFF with tx_valid held high → second accept occurs one IDLE cycle after the first tx_done. Both frames are bit-exact.
4. tx_valid toggled with random data while busy → ignored. The transmitted byte equals the one accepted.
5. Assert reset during data bit 3 of 0x3C → tx=1, busy=0, tx_ready=1 immediately. After release, a new 0x81 frame is correct.
6. With UART_TX_PARITY_EN defined, send 0x07 → parity bit 1. Send 0x03 → parity bit 0. tx_done arrives 44 cycles after accept.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path (and later the receiver).
//   - state_t    : controller states IDLE, START, DATA, PARITY, STOP
//   - DATA_BITS  : data bits per frame, fixed to the PISO width
//   - BIT_IDX_W  : width of a counter that indexes the data bits
//   - cntWidth() : width needed for a counter running 0..n-1 (at least 1)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_IDX_W = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // ceil(log2(n)) with a floor of 1, so that a divide-by-2 baud counter
    // still gets a real one-bit register.
    function automatic int cntWidth(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) < n) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// ---------------------------------------------------------------------------
// uart_baud_counter
// Free-running baud counter 0..CLKS_PER_BIT-1. Held at zero while i_clear is
// high, wraps by itself at the end of every bit period.
// Ports:
//   i_clk      : system clock
//   i_rst_n    : asynchronous active-low reset
//   i_clear    : synchronous clear, holds the count at 0
//   o_bit_end  : high in the last clock of a bit (count == CLKS_PER_BIT-1)
// ---------------------------------------------------------------------------
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_bit_end
);

    localparam int CNT_W = cntWidth(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    // Count up through the bit period and restart, so consecutive bits are
    // timed back to back without the controller having to reload anything.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (r_count == LAST_CNT) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_bit_end = (r_count == LAST_CNT);

endmodule

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmit controller sitting between a byte source and an external
// 8-bit PISO. It accepts a byte over valid/ready, loads the PISO, issues
// baud-aligned shift strobes and frames the PISO output on the tx line as
// start bit, 8 data bits (MSB first), optional even parity, stop bit.
//
// Build option: define UART_TX_PARITY_EN to insert an even parity bit
// between the last data bit and the stop bit.
//
// Ports:
//   i_clk        : system clock
//   i_rst_n      : asynchronous active-low reset (aborts a frame, tx -> 1)
//   i_tx_data    : byte to send, taken on the accept cycle
//   i_tx_valid   : source has a byte
//   o_tx_ready   : controller can accept (IDLE only)
//   o_piso_data  : parallel word to the PISO (pass-through of i_tx_data)
//   o_piso_load  : one-cycle PISO load strobe (accept cycle)
//   o_piso_shift : one-cycle PISO shift strobe (last clock of a bit)
//   i_piso_out   : registered serial bit from the PISO, MSB first
//   o_tx         : UART line, idle high
//   o_busy       : high from the accept edge until the frame completes
//   o_tx_done    : one-cycle pulse in the last clock of the stop bit
// ---------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic [DATA_BITS-1:0] o_piso_data,
    output logic                 o_piso_load,
    output logic                 o_piso_shift,
    input  logic                 i_piso_out,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_tx_done
);

    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [BIT_IDX_W-1:0]   r_bit_idx;
    logic                   w_bit_end;
    logic                   w_clear;
    logic                   w_parity;

    // The counter sits at zero in IDLE so the START bit always gets a full
    // bit period measured from the accept edge.
    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_clear),
        .o_bit_end (w_bit_end)
    );

`ifdef UART_TX_PARITY_EN
    logic [DATA_BITS-1:0] r_data;

    // The PISO consumes the byte, so a private copy is kept for parity.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
        end else if (r_state == IDLE && i_tx_valid) begin
            r_data <= i_tx_data;
        end
    end

    assign w_parity = ^r_data;
`else
    assign w_parity = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Data bit index; only meaningful in DATA, parked at zero elsewhere.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_idx <= '0;
        end else if (r_state != DATA) begin
            r_bit_idx <= '0;
        end else if (w_bit_end) begin
            r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
        end
    end

    // Next state and strobes. The shift issued at the end of START makes the
    // PISO present bit 7 on the same edge the FSM enters DATA; the last data
    // bit gets no shift because nothing follows it in the PISO.
    always_comb begin
        w_next_state = r_state;
        o_piso_load  = 1'b0;
        o_piso_shift = 1'b0;
        o_tx_done    = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            IDLE: begin
                w_clear = 1'b1;
                if (i_tx_valid) begin
                    o_piso_load  = 1'b1;
                    w_next_state = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    o_piso_shift = 1'b1;
                    w_next_state = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        w_next_state = PARITY;
`else
                        w_next_state = STOP;
`endif
                    end else begin
                        o_piso_shift = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    o_tx_done    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Line driver: selects only between constants, the registered PISO bit
    // and the registered-byte parity, so tx never sees a glitchy input path.
    always_comb begin
        o_tx = 1'b1;
        case (r_state)
            START:   o_tx = 1'b0;
            DATA:    o_tx = i_piso_out;
            PARITY:  o_tx = w_parity;
            default: o_tx = 1'b1;
        endcase
    end

    assign o_tx_ready  = (r_state == IDLE);
    assign o_busy      = (r_state != IDLE);
    assign o_piso_data = i_tx_data;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Drives bytes into uart_tx_ctrl with a behavioural PISO attached. Accepted
// bytes go into a scoreboard queue; a monitor rebuilds the expected line
// waveform for each frame from the UART framing rules and checks the DUT
// cycle by cycle. Define UART_TX_PARITY_EN for the parity variant.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYCLES = FRAME_BITS * CPB;

    logic       clk;
    logic       rst_n;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady;
    logic [7:0] pisoData;
    logic       pisoLoad;
    logic       pisoShift;
    logic       pisoOut;
    logic       tx;
    logic       busy;
    logic       txDone;

    int vectors     = 0;
    int miscompares = 0;
    int cycleCount  = 0;

    logic [7:0] sb[$];

    uart_tx_ctrl #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_tx_data    (txData),
        .i_tx_valid   (txValid),
        .o_tx_ready   (txReady),
        .o_piso_data  (pisoData),
        .o_piso_load  (pisoLoad),
        .o_piso_shift (pisoShift),
        .i_piso_out   (pisoOut),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_tx_done    (txDone)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle stamp used for inter-accept spacing.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Behavioural 8-bit PISO: load captures the word, each shift presents the
    // next MSB on its registered output.
    logic [7:0] pisoReg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pisoReg <= 8'h00;
            pisoOut <= 1'b1;
        end else if (pisoLoad) begin
            pisoReg <= pisoData;
        end else if (pisoShift) begin
            pisoOut <= pisoReg[7];
            pisoReg <= {pisoReg[6:0], 1'b0};
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    // Line level of frame bit position pos for byte b: start, MSB-first
    // data, optional even parity, stop.
    function automatic logic frameBit(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[8 - pos];
`ifdef UART_TX_PARITY_EN
        if (pos == 9) return ($countones(b) % 2) == 1;
`endif
        return 1'b1;
    endfunction

    // Monitor: samples on the falling edge, pops the scoreboard on every
    // accept and compares the following frame against the expected waveform.
    logic       expTx[$];
    bit         active = 0;
    int         cyc    = 0;
    int         shifts = 0;
    logic [7:0] expByte;

    always @(negedge clk) begin
        if (!rst_n) begin
            active = 0;
            checkOutput("rst_tx", tx, 1);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_ready", txReady, 1);
            checkOutput("rst_done", txDone, 0);
            checkOutput("rst_load", pisoLoad, 0);
            checkOutput("rst_shift", pisoShift, 0);
        end else begin
            checkOutput("strobe_overlap", pisoLoad & pisoShift, 0);
            if (active) begin
                cyc++;
                checkOutput("load_in_frame", pisoLoad, 0);
                checkOutput("tx_bit", tx, expTx[cyc-1]);
                checkOutput("busy_in_frame", busy, 1);
                checkOutput("ready_in_frame", txReady, 0);
                checkOutput("tx_done_timing", txDone, cyc == FRAME_CYCLES);
                if (pisoShift) shifts++;
                if (cyc == FRAME_CYCLES) begin
                    checkOutput("shift_count", shifts, 8);
                    active = 0;
                end
            end else begin
                checkOutput("idle_tx", tx, 1);
                checkOutput("idle_busy", busy, 0);
                checkOutput("idle_ready", txReady, 1);
                checkOutput("idle_done", txDone, 0);
                checkOutput("idle_shift", pisoShift, 0);
                checkOutput("load_vs_accept", pisoLoad, txValid);
                if (txValid && txReady) begin
                    checkOutput("piso_data", pisoData, txData);
                    checkOutput("scoreboard_has_entry", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        expByte = sb.pop_front();
                        expTx.delete();
                        for (int p = 0; p < FRAME_BITS; p++)
                            for (int k = 0; k < CPB; k++)
                                expTx.push_back(frameBit(expByte, p));
                        active = 1;
                        cyc    = 0;
                        shifts = 0;
                    end
                end
            end
        end
    end

    // Wait (bounded) for the cycle in which the DUT takes the byte.
    task automatic waitAccept(output int stamp);
        bit got;
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (txValid && txReady) got = 1;
        end
        stamp = cycleCount;
        checkOutput("accept_seen", got, 1);
    endtask

    // Wait (bounded) until the frame has finished.
    task automatic waitIdle();
        for (int i = 0; i < 400 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("frame_ended", busy, 0);
    endtask

    // Send one byte; optionally wiggle valid/data randomly while busy.
    task automatic applyStimulus(input logic [7:0] b, input bit noisy);
        int stamp;
        sb.push_back(b);
        txData  = b;
        txValid = 1'b1;
        waitAccept(stamp);
        @(posedge clk);
        #1;
        txValid = 1'b0;
        if (noisy) begin
            for (int i = 0; i < 400 && busy; i++) begin
                txValid = 1'($urandom_range(0, 1));
                txData  = 8'($urandom);
                @(posedge clk);
                #1;
            end
            txValid = 1'b0;
        end
        waitIdle();
    endtask

    initial begin
        int a1;
        int a2;
        txData  = 8'h00;
        txValid = 1'b0;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] idle after reset");
        repeat (100) @(posedge clk);
        #1;

        $display("[TB] single byte 0xA5");
        applyStimulus(8'hA5, 0);

        $display("[TB] back-to-back 0x00 then 0xFF");
        sb.push_back(8'h00);
        sb.push_back(8'hFF);
        txData  = 8'h00;
        txValid = 1'b1;
        waitAccept(a1);
        @(posedge clk);
        #1 txData = 8'hFF;
        waitAccept(a2);
        checkOutput("back_to_back_gap", a2 - a1, FRAME_CYCLES + 1);
        @(posedge clk);
        #1 txValid = 1'b0;
        waitIdle();

        $display("[TB] random bytes with noisy valid while busy");
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            applyStimulus(8'($urandom), 1);
        end

        $display("[TB] reset during data bit 3 of 0x3C");
        sb.push_back(8'h3C);
        txData  = 8'h3C;
        txValid = 1'b1;
        waitAccept(a1);
        @(posedge clk);
        #1 txValid = 1'b0;
        repeat (17) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_tx", tx, 1);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_ready", txReady, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(8'h81, 0);

`ifdef UART_TX_PARITY_EN
        $display("[TB] parity frames");
        applyStimulus(8'h07, 0);
        applyStimulus(8'h03, 0);
`endif

        repeat (5) @(posedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit in case a wait escapes its own bound.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
